// File: rtl/led_seq_pkg.sv
// Shared types and field widths for the LED fade sequencer and its channels.
package led_seq_pkg;

    localparam int CH_W     = 3;
    localparam int TARGET_W = 8;
    localparam int RATE_W   = 8;
    localparam int WIDTH_W  = 8;

    typedef logic [WIDTH_W-1:0] width_t;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_UP   = 2'd1,
        CH_DOWN = 2'd2
    } ch_state_t;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: ramp FSM, rate counter and PWM comparator.
// With LED_SEQ_BREATHE_EN defined, looped commands breathe between target and 0.
module led_fade_channel
    import led_seq_pkg::*;
(
    input  logic              clk_50,
    input  logic              reset,
    input  logic              load,
    input  width_t            cmd_target,
    input  logic [RATE_W-1:0] cmd_rate,
    input  logic              cmd_loop,
    input  logic              step_tick,
    input  width_t            pwm_pos,
    output logic              led,
    output logic              busy,
    output logic              done
);

    ch_state_t         state;
    width_t            width;
    width_t            target;
    width_t            dest;
    width_t            w_next;
    logic [RATE_W-1:0] rate;
    logic [RATE_W-1:0] rate_cnt;
    logic [RATE_W-1:0] rate_cnt_inc;
    logic              step_due;

    function automatic width_t sat_inc(input width_t w, input width_t lim);
        return (w >= lim) ? lim : w + WIDTH_W'(1);
    endfunction

    function automatic width_t sat_dec(input width_t w, input width_t lim);
        return (w <= lim) ? lim : w - WIDTH_W'(1);
    endfunction

`ifdef LED_SEQ_BREATHE_EN
    logic loop_r;
    logic to_zero;

    always_comb begin
        dest = target;
        if (to_zero) dest = '0;
    end
`else
    logic unused_loop;
    assign unused_loop = cmd_loop;

    always_comb begin
        dest = target;
    end
`endif

    assign rate_cnt_inc = rate_cnt + RATE_W'(1);
    // A rate of 0 behaves like 1: one LSB per step tick.
    assign step_due     = (rate == '0) || (rate_cnt_inc == rate);
    assign w_next       = (state == CH_UP) ? sat_inc(width, dest) : sat_dec(width, dest);
    assign busy         = (state != CH_IDLE);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state    <= CH_IDLE;
            width    <= '0;
            target   <= '0;
            rate     <= '0;
            rate_cnt <= '0;
            led      <= 1'b0;
            done     <= 1'b0;
`ifdef LED_SEQ_BREATHE_EN
            loop_r   <= 1'b0;
            to_zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            led  <= (pwm_pos < width);
            if (load) begin
                target   <= cmd_target;
                rate     <= cmd_rate;
                rate_cnt <= '0;
`ifdef LED_SEQ_BREATHE_EN
                loop_r   <= cmd_loop;
                to_zero  <= 1'b0;
`endif
                if (cmd_target > width) begin
                    state <= CH_UP;
                end else if (cmd_target < width) begin
                    state <= CH_DOWN;
                end else begin
                    state <= CH_IDLE;
                    done  <= 1'b1;
                end
            end else if (busy && step_tick) begin
                if (!step_due) begin
                    rate_cnt <= rate_cnt_inc;
                end else begin
                    rate_cnt <= '0;
                    width    <= w_next;
                    if (w_next == dest) begin
`ifdef LED_SEQ_BREATHE_EN
                        if (loop_r && target != '0) begin
                            if (to_zero) begin
                                to_zero <= 1'b0;
                                state   <= CH_UP;
                            end else begin
                                done    <= 1'b1;
                                to_zero <= 1'b1;
                                state   <= CH_DOWN;
                            end
                        end else begin
                            state <= CH_IDLE;
                            done  <= 1'b1;
                        end
`else
                        state <= CH_IDLE;
                        done  <= 1'b1;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: rtl/led_fade_sequencer.sv
// Multi-channel LED fade sequencer: shared PWM slot counter and step prescaler,
// one led_fade_channel per LED. Optional breathe mode: LED_SEQ_BREATHE_EN.
module led_fade_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 2500,
    parameter int STEP_DIV = 100000
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CH_W-1:0]     cmd_ch,
    input  logic [TARGET_W-1:0] cmd_target,
    input  logic [RATE_W-1:0]   cmd_rate,
    input  logic                cmd_loop,
    output logic [NUM_CH-1:0]   led,
    output logic [NUM_CH-1:0]   busy,
    output logic [NUM_CH-1:0]   ch_done,
    output logic                cmd_err
);

    localparam int TICK_CW = $clog2(TICK_DIV + 1);
    localparam int STEP_CW = $clog2(STEP_DIV + 1);
    localparam logic [TICK_CW-1:0] TICK_LAST = TICK_CW'(TICK_DIV - 1);
    localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(STEP_DIV - 1);

    logic [TICK_CW-1:0] tick_cnt;
    logic [STEP_CW-1:0] step_cnt;
    width_t             pwm_pos;
    logic               step_tick;
    logic               cmd_accept;
    logic               ch_in_range;

    assign cmd_ready   = ~reset;
    assign cmd_accept  = cmd_valid && cmd_ready;
    assign ch_in_range = ({1'b0, cmd_ch} < (CH_W + 1)'(NUM_CH));
    assign step_tick   = (step_cnt == STEP_LAST);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            tick_cnt <= '0;
            step_cnt <= '0;
            pwm_pos  <= '0;
            cmd_err  <= 1'b0;
        end else begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                pwm_pos  <= pwm_pos + WIDTH_W'(1);
            end else begin
                tick_cnt <= tick_cnt + TICK_CW'(1);
            end
            if (step_tick) step_cnt <= '0;
            else           step_cnt <= step_cnt + STEP_CW'(1);
            cmd_err <= cmd_accept && !ch_in_range;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_fade_channel u_ch (
            .clk_50     (clk_50),
            .reset      (reset),
            .load       (cmd_accept && ch_in_range && (cmd_ch == CH_W'(i))),
            .cmd_target (cmd_target),
            .cmd_rate   (cmd_rate),
            .cmd_loop   (cmd_loop),
            .step_tick  (step_tick),
            .pwm_pos    (pwm_pos),
            .led        (led[i]),
            .busy       (busy[i]),
            .done       (ch_done[i])
        );
    end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer with TICK_DIV=4, STEP_DIV=8.
module tb_led_fade_sequencer;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_ch = '0;
    logic [7:0] cmd_target = '0;
    logic [7:0] cmd_rate = '0;
    logic       cmd_loop = 1'b0;
    logic [3:0] led, busy, ch_done;
    logic       cmd_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done0_cnt = 0;

    typedef struct {
        int off;
        int ch;
        int width;
        int busy;
        int done;
    } vec_t;

    vec_t vecs[$];

    led_fade_sequencer #(.NUM_CH(4), .TICK_DIV(4), .STEP_DIV(8)) dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_target (cmd_target),
        .cmd_rate   (cmd_rate),
        .cmd_loop   (cmd_loop),
        .led        (led),
        .busy       (busy),
        .ch_done    (ch_done),
        .cmd_err    (cmd_err)
    );

    always #5 clk_50 = ~clk_50;

    always @(posedge clk_50) begin
        cyc <= reset ? 0 : cyc + 1;
        if (ch_done[0]) done0_cnt <= done0_cnt + 1;
    end

    function automatic int width_of(input int ch);
        case (ch)
            0:       return int'(dut.g_ch[0].u_ch.width);
            1:       return int'(dut.g_ch[1].u_ch.width);
            2:       return int'(dut.g_ch[2].u_ch.width);
            default: return int'(dut.g_ch[3].u_ch.width);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic goto(input int t);
        int guard = 0;
        while (cyc < t && guard < 20000) begin
            tick();
            guard++;
        end
        check($sformatf("reach_cycle_%0d", t), cyc, t);
    endtask

    task automatic send(input int ch, input int tgt, input int rate, input bit loop);
        cmd_valid  = 1'b1;
        cmd_ch     = 3'(ch);
        cmd_target = 8'(tgt);
        cmd_rate   = 8'(rate);
        cmd_loop   = loop;
        tick();
        cmd_valid  = 1'b0;
        cmd_loop   = 1'b0;
    endtask

    task automatic add(input int off, input int ch, input int w, input int b, input int d);
        vec_t v;
        v.off = off; v.ch = ch; v.width = w; v.busy = b; v.done = d;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input int base, input string tag);
        for (int k = 0; k < vecs.size(); k++) begin
            goto(base + vecs[k].off);
            check($sformatf("%s[%0d] width", tag, k), width_of(vecs[k].ch), vecs[k].width);
            check($sformatf("%s[%0d] busy", tag, k), int'(busy[vecs[k].ch]), vecs[k].busy);
            check($sformatf("%s[%0d] ch_done", tag, k), int'(ch_done[vecs[k].ch]), vecs[k].done);
        end
        vecs.delete();
    endtask

    initial begin
        int base;
        int d0;
        int hi0;
        int hi_other;

        // Reset state
        repeat (3) tick();
        check("rst led", int'(led), 0);
        check("rst busy", int'(busy), 0);
        check("rst ch_done", int'(ch_done), 0);
        check("rst cmd_err", int'(cmd_err), 0);
        check("rst cmd_ready", int'(cmd_ready), 0);
        reset = 1'b0;
        #1;
        check("cmd_ready after reset", int'(cmd_ready), 1);

        // ch0 ramp 0 -> 4 at rate 0, one LSB per step tick
        d0 = done0_cnt;
        send(0, 4, 0, 0);
        add(1, 0, 0, 1, 0);  add(8, 0, 1, 1, 0);  add(15, 0, 1, 1, 0);
        add(16, 0, 2, 1, 0); add(24, 0, 3, 1, 0); add(31, 0, 3, 1, 0);
        add(32, 0, 4, 0, 1); add(33, 0, 4, 0, 0);
        run_vecs(0, "ramp0");
        goto(40);
        check("ch0 done pulse count", done0_cnt - d0, 1);

        // PWM duty over one full 256-slot frame
        hi0 = 0;
        hi_other = 0;
        for (int k = 0; k < 1024; k++) begin
            tick();
            if (led[0]) hi0++;
            if (led[3:1] != 3'b000) hi_other++;
        end
        check("led0 high cycles per frame", hi0, 16);
        check("idle led high cycles", hi_other, 0);

        // Command equal to current width
        send(0, 4, 0, 0);
        check("eq busy", int'(busy[0]), 0);
        check("eq ch_done", int'(ch_done[0]), 1);
        check("eq width", width_of(0), 4);
        tick();
        check("eq ch_done drop", int'(ch_done[0]), 0);

        // Out-of-range channel
        send(7, 200, 0, 0);
        check("err pulse", int'(cmd_err), 1);
        check("err busy", int'(busy), 0);
        check("err w0", width_of(0), 4);
        check("err w1", width_of(1), 0);
        check("err w2", width_of(2), 0);
        check("err w3", width_of(3), 0);
        tick();
        check("err pulse drop", int'(cmd_err), 0);

        // ch1 up at rate 2, redirected down after 5 steps
        base = ((cyc / 8) + 1) * 8;
        goto(base);
        send(1, 10, 2, 0);
        add(1, 1, 0, 1, 0);  add(8, 1, 0, 1, 0);  add(16, 1, 1, 1, 0);
        add(32, 1, 2, 1, 0); add(48, 1, 3, 1, 0); add(64, 1, 4, 1, 0);
        add(79, 1, 4, 1, 0); add(80, 1, 5, 1, 0);
        run_vecs(base, "up1");
        send(1, 3, 2, 0);
        add(81, 1, 5, 1, 0);  add(95, 1, 5, 1, 0);  add(96, 1, 4, 1, 0);
        add(111, 1, 4, 1, 0); add(112, 1, 3, 0, 1); add(113, 1, 3, 0, 0);
        run_vecs(base, "down1");

        // Command landing on a step tick of the same channel
        base = ((cyc / 8) + 1) * 8;
        goto(base);
        send(2, 5, 3, 0);
        goto(base + 23);
        send(2, 6, 3, 0);
        check("coincide width", width_of(2), 0);
        check("coincide rate_cnt", int'(dut.g_ch[2].u_ch.rate_cnt), 0);
        check("coincide busy", int'(busy[2]), 1);
        add(47, 2, 0, 1, 0); add(48, 2, 1, 1, 0);
        run_vecs(base, "coin2");

        // Reset in the middle of a ramp
        reset = 1'b1;
        tick();
        check("midrst led", int'(led), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst ch_done", int'(ch_done), 0);
        check("midrst cmd_err", int'(cmd_err), 0);
        check("midrst cmd_ready", int'(cmd_ready), 0);
        check("midrst w0", width_of(0), 0);
        check("midrst w2", width_of(2), 0);
        reset = 1'b0;

        // Looped command: breathes with the option, plain ramp without it
        send(3, 3, 0, 1);
`ifdef LED_SEQ_BREATHE_EN
        add(8, 3, 1, 1, 0);  add(16, 3, 2, 1, 0); add(24, 3, 3, 1, 1);
        add(32, 3, 2, 1, 0); add(40, 3, 1, 1, 0); add(48, 3, 0, 1, 0);
        add(56, 3, 1, 1, 0); add(64, 3, 2, 1, 0);
        run_vecs(0, "breathe3");
`else
        add(8, 3, 1, 1, 0);  add(16, 3, 2, 1, 0); add(24, 3, 3, 0, 1);
        add(32, 3, 3, 0, 0); add(48, 3, 3, 0, 0);
        run_vecs(0, "noloop3");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
